// File: rtl/ioctl_upload_server.sv
// ioctl_upload_server: serves a RAM window to the HPS over the ioctl upload path.
// Define UPLOAD_CHECKSUM_EN to return ~(sum of served bytes) at offset LEN.
module ioctl_upload_server #(
  parameter int         ADDR_W = 12,
  parameter int         BASE   = 0,
  parameter int         LEN    = 256,
  parameter logic [7:0] INDEX  = 8'd4,
  parameter int         RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ioctl_upload,
  input  logic [7:0]        ioctl_index,
  input  logic [24:0]       ioctl_addr,
  input  logic              ioctl_rd,
  output logic [7:0]        ioctl_din,
  output logic              ioctl_wait,
  output logic              ioctl_upload_req,
  input  logic              autosave,
  input  logic              osd_open,
  output logic              pause_req,
  input  logic              paused,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rd,
  input  logic [7:0]        ram_q,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr
);
  typedef enum logic [1:0] {IDLE, PAUSE, READY, FETCH} state_t;
  state_t state, state_nx;
  logic upload_q, osd_q, pend, dirty, start, stop, req, hit, done, wr_hit;
  logic [24:0] offs, a;
  logic [1:0] cnt;
  logic [7:0] oor;
  logic [31:0] woff;
  assign start = ioctl_upload && !upload_q && ioctl_index == INDEX;
  assign stop = !ioctl_upload && state != IDLE;
  assign req = state == READY && (pend || ioctl_rd);
  assign a = pend ? offs : ioctl_addr;
  assign hit = a < 25'(LEN);
  assign done = state == FETCH && cnt == 2'(RD_LAT);
  // unsigned wrap makes addresses below BASE compare as huge, so one test covers both bounds
  assign woff = 32'(cpu_addr) - 32'(BASE);
  assign wr_hit = cpu_wr && woff < 32'(LEN);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    pause_req = 1'b0;
    ioctl_wait = 1'b0;
    ram_rd = 1'b0;
    ram_addr = '0;
    state_nx = stop ? IDLE :
               state == IDLE && start ? PAUSE :
               state == PAUSE && paused ? READY :
               req && hit ? FETCH :
               done ? READY : state;
    pause_req = state != IDLE;
    ioctl_wait = state == PAUSE || state == FETCH || (state == READY && pend);
    ram_rd = state == FETCH && cnt == 2'd0;
    ram_addr = state == FETCH ? ADDR_W'(BASE) + offs[ADDR_W-1:0] : '0;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      upload_q <= 1'b0;
      osd_q <= 1'b0;
      ioctl_upload_req <= 1'b0;
      dirty <= 1'b0;
      cnt <= 2'd0;
      pend <= 1'b0;
      offs <= '0;
      ioctl_din <= 8'h00;
    end else begin
      upload_q <= ioctl_upload;
      osd_q <= osd_open;
      ioctl_upload_req <= osd_open && !osd_q && autosave && dirty && state == IDLE;
      dirty <= wr_hit || (dirty && !stop);
      cnt <= state == FETCH && !done ? cnt + 2'd1 : 2'd0;
      pend <= !stop && (state == PAUSE ? pend || ioctl_rd : pend && !req);
      if (state == PAUSE && ioctl_rd) offs <= ioctl_addr;
      else if (req) offs <= a;
      if (!stop && req && !hit) ioctl_din <= oor;
      else if (!stop && done) ioctl_din <= ram_q;
    end
`ifdef UPLOAD_CHECKSUM_EN
  logic [7:0] acc;
  assign oor = a == 25'(LEN) ? ~acc : 8'hFF;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) acc <= 8'h00;
    else if (done && !stop) acc <= (offs == '0 ? 8'h00 : acc) + ram_q;
`else
  assign oor = 8'hFF;
`endif
endmodule

// File: tb/tb_ioctl_upload_server.sv
// tb_ioctl_upload_server: table vectors, hand sequences and randomized reads against a memory model.
module tb_ioctl_upload_server;
  localparam int ADDR_W = 12;
  localparam int BASE = 16;
  localparam int LEN = 200;
  localparam logic [7:0] INDEX = 8'd4;
  localparam int RD_LAT = 1;

  logic clk = 0, reset_n = 0;
  logic ioctl_upload = 0, ioctl_rd = 0, autosave = 0, osd_open = 0, paused = 0, cpu_wr = 0;
  logic [7:0] ioctl_index = 0, ioctl_din, ram_q;
  logic [24:0] ioctl_addr = 0;
  logic ioctl_wait, ioctl_upload_req, pause_req, ram_rd;
  logic [ADDR_W-1:0] ram_addr, cpu_addr = 0;

  ioctl_upload_server #(.ADDR_W(ADDR_W), .BASE(BASE), .LEN(LEN), .INDEX(INDEX), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .reset_n(reset_n), .ioctl_upload(ioctl_upload), .ioctl_index(ioctl_index),
    .ioctl_addr(ioctl_addr), .ioctl_rd(ioctl_rd), .ioctl_din(ioctl_din), .ioctl_wait(ioctl_wait),
    .ioctl_upload_req(ioctl_upload_req), .autosave(autosave), .osd_open(osd_open),
    .pause_req(pause_req), .paused(paused), .ram_addr(ram_addr), .ram_rd(ram_rd),
    .ram_q(ram_q), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr));

  always #5 clk = ~clk;

  // RAM model: data appears RD_LAT cycles after a strobed address; unstrobed cycles return EE
  logic [7:0] mem [1 << ADDR_W];
  logic [7:0] pipe [RD_LAT];
  always @(posedge clk) begin
    pipe[0] <= ram_rd ? mem[ram_addr] : 8'hEE;
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign ram_q = pipe[RD_LAT-1];

  typedef struct {logic [24:0] off; logic [7:0] d; int w; int r;} vec_t;
  typedef struct {logic [ADDR_W-1:0] addr; logic as; int p;} dvec_t;
  vec_t tbl[6];
  dvec_t dtbl[5];
  int nvec = 0, nerr = 0;
  logic [7:0] m_acc = 0, last_d = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] model_d(input logic [24:0] off);
    if (32'(off) < LEN) return mem[BASE + int'(off)];
`ifdef UPLOAD_CHECKSUM_EN
    if (32'(off) == LEN) return ~m_acc;
`endif
    return 8'hFF;
  endfunction

  task automatic rd(input logic [24:0] off, output logic [7:0] d, output int w, output int r);
    ioctl_addr = off;
    ioctl_rd = 1;
    @(negedge clk);
    ioctl_rd = 0;
    w = 0;
    r = 0;
    for (int i = 0; i < 20 && ioctl_wait; i++) begin
      w++;
      r += int'(ram_rd);
      @(negedge clk);
    end
    d = ioctl_din;
  endtask

  task automatic rd_chk(input string nm, input logic [24:0] off, input logic [7:0] ed, input int ew, input int er);
    logic [7:0] d;
    int w, r;
    rd(off, d, w, r);
    chk({nm, " data"}, 32'(d), 32'(ed));
    chk({nm, " wait cycles"}, w, ew);
    chk({nm, " ram_rd cycles"}, r, er);
    if (32'(off) < LEN) m_acc = (off == 0 ? 8'h00 : m_acc) + ed;
    last_d = ed;
  endtask

  task automatic osd_pulse(output int p, output logic first);
    osd_open = 1;
    @(negedge clk);
    first = ioctl_upload_req;
    p = int'(ioctl_upload_req);
    osd_open = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      p += int'(ioctl_upload_req);
    end
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a);
    cpu_addr = a;
    cpu_wr = 1;
    @(negedge clk);
    cpu_wr = 0;
  endtask

  task automatic to_ready();
    for (int i = 0; i < 10 && ioctl_wait; i++) @(negedge clk);
    chk("reach READY", ioctl_wait, 0);
  endtask

  function automatic logic [31:0] outs();
    return 32'({ioctl_din, ioctl_wait, ioctl_upload_req, pause_req, ram_addr, ram_rd});
  endfunction

  initial begin
    int p, w;
    logic first;
    logic [7:0] s, csum0, csum1;
    logic [24:0] off;
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 8'($urandom);
    for (int i = 0; i < LEN; i++) mem[BASE + i] = 8'(i) ^ 8'h5A;
    s = 0;
    for (int i = 0; i < LEN; i++) s += 8'(i) ^ 8'h5A;
`ifdef UPLOAD_CHECKSUM_EN
    csum0 = ~s;
    csum1 = ~8'h5A;
`else
    csum0 = 8'hFF;
    csum1 = 8'hFF;
`endif
    tbl[0] = '{25'(LEN), csum0, 0, 0};
    tbl[1] = '{25'(LEN - 1), 8'(LEN - 1) ^ 8'h5A, RD_LAT + 1, 1};
    tbl[2] = '{25'(LEN + 5), 8'hFF, 0, 0};
    tbl[3] = '{25'h1000003, 8'hFF, 0, 0};
    tbl[4] = '{25'd0, 8'h5A, RD_LAT + 1, 1};
    tbl[5] = '{25'(LEN), csum1, 0, 0};
    dtbl[0] = '{ADDR_W'(BASE + LEN), 1'b1, 0};
    dtbl[1] = '{ADDR_W'(BASE - 1), 1'b1, 0};
    dtbl[2] = '{ADDR_W'(BASE + LEN - 1), 1'b0, 0};
    dtbl[3] = '{ADDR_W'(BASE + LEN + 7), 1'b1, 1};
    dtbl[4] = '{ADDR_W'(BASE), 1'b1, 1};

    @(negedge clk);
    chk("outputs in reset", outs(), 0);
    @(negedge clk);
    reset_n = 1;
    @(negedge clk);
    chk("outputs after reset", outs(), 0);

    foreach (dtbl[k]) begin
      autosave = dtbl[k].as;
      wr(dtbl[k].addr);
      osd_pulse(p, first);
      chk($sformatf("dirty vec %0d pulses", k), p, dtbl[k].p);
      chk($sformatf("dirty vec %0d timing", k), 32'(first), 32'(dtbl[k].p));
    end
    autosave = 1;

    ioctl_index = INDEX;
    ioctl_upload = 1;
    @(negedge clk);
    chk("pause_req after session edge", pause_req, 1);
    ioctl_addr = 3;
    ioctl_rd = 1;
    @(negedge clk);
    ioctl_rd = 0;
    w = 0;
    for (int i = 0; i < 5; i++) begin
      w += int'(ioctl_wait);
      @(negedge clk);
    end
    chk("wait held while unpaused", w, 5);
    paused = 1;
    for (int i = 0; i < 20 && ioctl_wait; i++) @(negedge clk);
    chk("held read served", 32'(ioctl_din), 32'(mem[BASE + 3]));
    chk("held read wait low", ioctl_wait, 0);

    for (int i = 0; i < LEN; i++) rd_chk($sformatf("dump %0d", i), 25'(i), 8'(i) ^ 8'h5A, RD_LAT + 1, 1);
    foreach (tbl[k]) rd_chk($sformatf("boundary %0d", k), tbl[k].off, tbl[k].d, tbl[k].w, tbl[k].r);

    for (int i = 0; i < LEN; i++) mem[BASE + i] = 8'($urandom);
    for (int k = 0; k < 40; k++) begin
      off = (k % 8 == 7) ? (25'($urandom) | 25'h1000000) : 25'($urandom_range(0, LEN + 8));
      rd_chk($sformatf("rand %0d off %0h", k, off), off, model_d(off),
             32'(off) < LEN ? RD_LAT + 1 : 0, 32'(off) < LEN ? 1 : 0);
    end
    osd_pulse(p, first);
    chk("no request outside IDLE", p, 0);

    mem[BASE + 10] = ~last_d;
    ioctl_addr = 10;
    ioctl_rd = 1;
    @(negedge clk);
    ioctl_rd = 0;
    chk("abort precondition fetch", {ioctl_wait, ram_rd}, 2'b11);
    ioctl_upload = 0;
    @(negedge clk);
    chk("abort pause_req", pause_req, 0);
    chk("abort wait", ioctl_wait, 0);
    chk("abort din kept", 32'(ioctl_din), 32'(last_d));
    paused = 0;
    osd_pulse(p, first);
    chk("dirty cleared by session end", p, 0);

    ioctl_upload = 1;
    paused = 1;
    @(negedge clk);
    to_ready();
    ioctl_upload = 0;
    cpu_addr = ADDR_W'(BASE + LEN - 1);
    cpu_wr = 1;
    @(negedge clk);
    cpu_wr = 0;
    paused = 0;
    chk("end pause_req", pause_req, 0);
    osd_pulse(p, first);
    chk("set wins over clear", p, 1);

    ioctl_index = 8'(INDEX + 1);
    ioctl_upload = 1;
    paused = 1;
    p = 0;
    w = 0;
    for (int i = 0; i < 6; i++) begin
      ioctl_rd = i == 2;
      @(negedge clk);
      p += int'(pause_req);
      w += int'(ioctl_wait);
    end
    chk("wrong index pause_req", p, 0);
    chk("wrong index wait", w, 0);
    ioctl_upload = 0;
    paused = 0;
    @(negedge clk);
    osd_pulse(p, first);
    chk("wrong index keeps dirty", p, 1);

    ioctl_index = INDEX;
    ioctl_upload = 1;
    paused = 1;
    @(negedge clk);
    to_ready();
    ioctl_addr = 20;
    ioctl_rd = 1;
    @(negedge clk);
    ioctl_rd = 0;
    chk("reset precondition ram_rd", ram_rd, 1);
    reset_n = 0;
    #1;
    chk("async reset outputs", outs(), 0);
    ioctl_upload = 0;
    paused = 0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1;
    @(negedge clk);
    chk("outputs after mid reset", outs(), 0);
    osd_pulse(p, first);
    chk("dirty cleared by reset", p, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
